// File: rtl/ahb_lite_manager.sv
// AHB-Lite manager bridge: turns a 32-bit request/response port into single
// word transfers on a 64-bit AHB-Lite bus, one transfer outstanding at a time.
module ahb_lite_manager #(
    parameter int AhbDataWidth = 64,
    parameter int AhbAddrWidth = 32,
    parameter int ReqDataWidth = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic                      req_write_i,
    input  logic [AhbAddrWidth-1:0]   req_addr_i,
    input  logic [ReqDataWidth-1:0]   req_wdata_i,
    input  logic [ReqDataWidth/8-1:0] req_wstrb_i,

    output logic                      rsp_valid_o,
    output logic                      rsp_err_o,
    output logic [ReqDataWidth-1:0]   rsp_rdata_o,

    output logic [AhbAddrWidth-1:0]   haddr_o,
    output logic [2:0]                hburst_o,
    output logic [3:0]                hprot_o,
    output logic [2:0]                hsize_o,
    output logic [1:0]                htrans_o,
    output logic                      hwrite_o,
    output logic [AhbDataWidth-1:0]   hwdata_o,
    output logic [AhbDataWidth/8-1:0] hwstrb_o,
    input  logic [AhbDataWidth-1:0]   hrdata_i,
    input  logic                      hready_i,
    input  logic                      hresp_i
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        ERR2,
        RESP
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_e                    state_q, state_d;
    logic                      resp_err;
    logic                      handshake;

    logic                      write_q, write_d;
    logic [AhbAddrWidth-1:0]   addr_q, addr_d;
    logic [ReqDataWidth-1:0]   wdata_q, wdata_d;
    logic [ReqDataWidth/8-1:0] wstrb_q, wstrb_d;

    logic [AhbAddrWidth-1:0]   haddr_q, haddr_d;
    logic [1:0]                htrans_q, htrans_d;
    logic                      hwrite_q, hwrite_d;
    logic [AhbDataWidth-1:0]   hwdata_q, hwdata_d;
    logic [AhbDataWidth/8-1:0] hwstrb_q, hwstrb_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_err_q, rsp_err_d;
    logic [ReqDataWidth-1:0]   rsp_rdata_q, rsp_rdata_d;

    assign req_ready_o = (state_q == IDLE) && !rst;
    assign handshake   = req_valid_i && req_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            haddr_q     <= '0;
            htrans_q    <= HTRANS_IDLE;
            hwrite_q    <= 1'b0;
            hwdata_q    <= '0;
            hwstrb_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            haddr_q     <= haddr_d;
            htrans_q    <= htrans_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            hwstrb_q    <= hwstrb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Misaligned requests never reach the bus; they go straight to an error response.
    always_comb begin
        state_d  = state_q;
        resp_err = 1'b0;
        write_d  = write_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        case (state_q)
            IDLE: begin
                if (handshake) begin
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wstrb_d = req_wstrb_i;
                    if (req_addr_i[1:0] != 2'b00) begin
                        state_d  = RESP;
                        resp_err = 1'b1;
                    end else begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (hready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (hready_i) begin
                    state_d  = RESP;
                    resp_err = hresp_i;
                end else if (hresp_i) begin
                    state_d = ERR2;
                end
            end
            ERR2: begin
                if (hready_i) begin
                    state_d  = RESP;
                    resp_err = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus and response registers are loaded from the state being entered.
    always_comb begin
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        htrans_d    = HTRANS_IDLE;
        hwdata_d    = '0;
        hwstrb_d    = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        case (state_d)
            ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                haddr_d  = addr_d;
                hwrite_d = write_d;
            end
            DATA: begin
                if (write_q) begin
                    hwdata_d = addr_q[2] ? {wdata_q, {ReqDataWidth{1'b0}}}
                                         : {{ReqDataWidth{1'b0}}, wdata_q};
                    hwstrb_d = addr_q[2] ? {wstrb_q, {(ReqDataWidth/8){1'b0}}}
                                         : {{(ReqDataWidth/8){1'b0}}, wstrb_q};
                end
            end
            RESP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = resp_err;
                if (!resp_err && !write_q) begin
                    rsp_rdata_d = addr_q[2] ? hrdata_i[AhbDataWidth-1:ReqDataWidth]
                                            : hrdata_i[ReqDataWidth-1:0];
                end
            end
            default: begin
            end
        endcase
    end

    assign haddr_o     = haddr_q;
    assign htrans_o    = htrans_q;
    assign hwrite_o    = hwrite_q;
    assign hwdata_o    = hwdata_q;
    assign hwstrb_o    = hwstrb_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign hburst_o    = 3'b000;
    assign hprot_o     = 4'b0011;
    assign hsize_o     = 3'b010;

endmodule

// File: tb/tb_ahb_lite_manager.sv
// Directed bench for ahb_lite_manager: inputs change 1ns after each rising
// edge, outputs are checked on the following falling edge.
module tb_ahb_lite_manager;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wstrb_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [31:0] rsp_rdata_o;
    logic [31:0] haddr_o;
    logic [2:0]  hburst_o;
    logic [3:0]  hprot_o;
    logic [2:0]  hsize_o;
    logic [1:0]  htrans_o;
    logic        hwrite_o;
    logic [63:0] hwdata_o;
    logic [7:0]  hwstrb_o;
    logic [63:0] hrdata_i;
    logic        hready_i;
    logic        hresp_i;

    int n_checks;
    int n_fail;

    ahb_lite_manager dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_write_i (req_write_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .req_wstrb_i (req_wstrb_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_rdata_o (rsp_rdata_o),
        .haddr_o     (haddr_o),
        .hburst_o    (hburst_o),
        .hprot_o     (hprot_o),
        .hsize_o     (hsize_o),
        .htrans_o    (htrans_o),
        .hwrite_o    (hwrite_o),
        .hwdata_o    (hwdata_o),
        .hwstrb_o    (hwstrb_o),
        .hrdata_i    (hrdata_i),
        .hready_i    (hready_i),
        .hresp_i     (hresp_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic apply_stimulus(input logic r, input logic valid, input logic wr,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb, input logic rdy,
                                  input logic resp, input logic [63:0] rdata);
        @(posedge clk);
        #1;
        rst         = r;
        req_valid_i = valid;
        req_write_i = wr;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wstrb_i = wstrb;
        hready_i    = rdy;
        hresp_i     = resp;
        hrdata_i    = rdata;
        @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [1:0] exp_htrans [0:8];
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        req_wstrb_i = '0;
        hrdata_i    = '0;
        hready_i    = 1'b1;
        hresp_i     = 1'b0;

        // Reset values
        apply_stimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        apply_stimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rst_ready", req_ready_o, 0);
        check_output("rst_rsp_valid", rsp_valid_o, 0);
        check_output("rst_rsp_err", rsp_err_o, 0);
        check_output("rst_rsp_rdata", rsp_rdata_o, 0);
        check_output("rst_haddr", haddr_o, 0);
        check_output("rst_htrans", htrans_o, 2'b00);
        check_output("rst_hwrite", hwrite_o, 0);
        check_output("rst_hwdata", hwdata_o, 0);
        check_output("rst_hwstrb", hwstrb_o, 0);
        check_output("const_hburst", hburst_o, 3'b000);
        check_output("const_hprot", hprot_o, 4'b0011);
        check_output("const_hsize", hsize_o, 3'b010);

        // Zero-wait write to the upper lane
        apply_stimulus(0, 1, 1, 32'h104, 32'hDEAD_BEEF, 4'hF, 1, 0, 64'h0);
        check_output("wr_T_ready", req_ready_o, 1);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("wr_T1_htrans", htrans_o, 2'b10);
        check_output("wr_T1_haddr", haddr_o, 32'h104);
        check_output("wr_T1_hwrite", hwrite_o, 1);
        check_output("wr_T1_ready", req_ready_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("wr_T2_htrans", htrans_o, 2'b00);
        check_output("wr_T2_hwdata", hwdata_o, 64'hDEAD_BEEF_0000_0000);
        check_output("wr_T2_hwstrb", hwstrb_o, 8'hF0);
        check_output("wr_T2_rsp_valid", rsp_valid_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("wr_T3_rsp_valid", rsp_valid_o, 1);
        check_output("wr_T3_rsp_err", rsp_err_o, 0);
        check_output("wr_T3_rsp_rdata", rsp_rdata_o, 0);
        check_output("wr_T3_hwdata", hwdata_o, 0);
        check_output("wr_T3_hwstrb", hwstrb_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("wr_T4_ready", req_ready_o, 1);
        check_output("wr_T4_rsp_valid", rsp_valid_o, 0);

        // Read of the lower lane with two data-phase wait states
        apply_stimulus(0, 1, 0, 32'h100, 32'h0, 4'h0, 1, 0, 64'h0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rd_T1_htrans", htrans_o, 2'b10);
        check_output("rd_T1_hwrite", hwrite_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 64'h0);
        check_output("rd_T2_htrans", htrans_o, 2'b00);
        check_output("rd_T2_haddr", haddr_o, 32'h100);
        check_output("rd_T2_hwstrb", hwstrb_o, 0);
        check_output("rd_T2_hwdata", hwdata_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 64'h0);
        check_output("rd_T3_haddr", haddr_o, 32'h100);
        check_output("rd_T3_hwrite", hwrite_o, 0);
        check_output("rd_T3_rsp_valid", rsp_valid_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h1111_2222_3333_4444);
        check_output("rd_T4_rsp_valid", rsp_valid_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rd_T5_rsp_valid", rsp_valid_o, 1);
        check_output("rd_T5_rsp_rdata", rsp_rdata_o, 32'h3333_4444);
        check_output("rd_T5_rsp_err", rsp_err_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rd_T6_ready", req_ready_o, 1);

        // Two-cycle ERROR response on a read
        apply_stimulus(0, 1, 0, 32'h104, 32'h0, 4'h0, 1, 0, 64'h0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("err_T1_htrans", htrans_o, 2'b10);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 64'h5555_6666_7777_8888);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 1, 64'h5555_6666_7777_8888);
        check_output("err_T3_rsp_valid", rsp_valid_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("err_T4_rsp_valid", rsp_valid_o, 1);
        check_output("err_T4_rsp_err", rsp_err_o, 1);
        check_output("err_T4_rsp_rdata", rsp_rdata_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("err_T5_ready", req_ready_o, 1);
        check_output("err_T5_rsp_valid", rsp_valid_o, 0);

        // Misaligned request: immediate error, no bus transfer
        apply_stimulus(0, 1, 0, 32'h102, 32'h0, 4'h0, 1, 0, 64'h0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("mis_T1_rsp_valid", rsp_valid_o, 1);
        check_output("mis_T1_rsp_err", rsp_err_o, 1);
        check_output("mis_T1_htrans", htrans_o, 2'b00);
        check_output("mis_T1_ready", req_ready_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("mis_T2_ready", req_ready_o, 1);
        check_output("mis_T2_htrans", htrans_o, 2'b00);
        check_output("mis_T2_rsp_valid", rsp_valid_o, 0);

        // Reset during a stalled write data phase (lower lane)
        apply_stimulus(0, 1, 1, 32'h108, 32'hCAFE_F00D, 4'h3, 1, 0, 64'h0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rstx_T1_htrans", htrans_o, 2'b10);
        apply_stimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 64'h0);
        check_output("rstx_T2_hwdata", hwdata_o, 64'h0000_0000_CAFE_F00D);
        check_output("rstx_T2_hwstrb", hwstrb_o, 8'h03);
        apply_stimulus(1, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 64'h0);
        check_output("rstx_T3_htrans", htrans_o, 2'b00);
        check_output("rstx_T3_hwdata", hwdata_o, 0);
        check_output("rstx_T3_rsp_valid", rsp_valid_o, 0);
        check_output("rstx_T3_ready", req_ready_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rstx_T4_ready", req_ready_o, 1);
        check_output("rstx_T4_rsp_valid", rsp_valid_o, 0);
        apply_stimulus(0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 64'h0);
        check_output("rstx_T5_rsp_valid", rsp_valid_o, 0);

        // Back-to-back reads with req_valid held high
        exp_htrans = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, (i < 8), 0, (i == 0) ? 32'h200 : 32'h204, 32'h0, 4'h0,
                           1, 0, 64'hAAAA_BBBB_CCCC_DDDD);
            check_output($sformatf("b2b_htrans_%0d", i), htrans_o, exp_htrans[i]);
            if (i == 0 || i == 4) check_output($sformatf("b2b_ready_%0d", i), req_ready_o, 1);
            if (i == 3) check_output("b2b_rdata_0", rsp_rdata_o, 32'hCCCC_DDDD);
            if (i == 5) check_output("b2b_haddr_1", haddr_o, 32'h204);
            if (i == 7) check_output("b2b_rdata_1", rsp_rdata_o, 32'hAAAA_BBBB);
            check_output($sformatf("b2b_rsp_valid_%0d", i), rsp_valid_o, (i == 3 || i == 7));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
